// File: rtl/chacha20_poly1305_stream.sv
// Word-stream sequencer for the ChaCha20-Poly1305 AEAD core: packs 32-bit words
// into 512-bit blocks, issues init/next/done, and unpacks results back to words.
module chacha20_poly1305_stream #(
  parameter int CTR_W = 32
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             start,
  output logic             busy,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [31:0]      in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [31:0]      out_data,
  output logic             out_last,
  output logic             core_init,
  output logic             core_next,
  output logic             core_done,
  input  logic             core_ready,
  input  logic             core_valid,
  output logic [511:0]     core_data_in,
  input  logic [511:0]     core_data_out,
  output logic [CTR_W-1:0] blocks_done
);

  typedef enum logic [2:0] {
    IDLE, FILL, ISSUE, WAIT_BUSY, WAIT_VALID, DRAIN, FINISH
  } state_t;

  state_t      state;
  logic [31:0] blk  [16];
  logic [31:0] obuf [16];
  logic [4:0]  wcnt;
  logic [3:0]  rd;
  logic        first;
  logic        last;
  logic        rd_final;

  always_comb begin
    core_data_in = '0;
    for (int unsigned k = 0; k < 16; k++) begin
      core_data_in[511-32*k -: 32] = blk[k[3:0]];
    end
  end

  always_comb begin
    rd_final  = ({1'b0, rd} == wcnt - 5'd1);
    in_ready  = (state == FILL);
    out_valid = (state == DRAIN);
    out_data  = (state == DRAIN) ? obuf[rd] : '0;
    out_last  = (state == DRAIN) && last && rd_final;
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state       <= IDLE;
      busy        <= 1'b0;
      first       <= 1'b0;
      last        <= 1'b0;
      wcnt        <= '0;
      rd          <= '0;
      core_init   <= 1'b0;
      core_next   <= 1'b0;
      core_done   <= 1'b0;
      blocks_done <= '0;
      for (int unsigned k = 0; k < 16; k++) begin
        blk[k[3:0]]  <= '0;
        obuf[k[3:0]] <= '0;
      end
    end else begin
      core_init <= 1'b0;
      core_next <= 1'b0;
      core_done <= 1'b0;
      unique case (state)
        IDLE: begin
          if (start) begin
            busy        <= 1'b1;
            first       <= 1'b1;
            blocks_done <= '0;
            wcnt        <= '0;
            rd          <= '0;
            // Stale words from a previous message must not leak into a partial block.
            for (int unsigned k = 0; k < 16; k++) blk[k[3:0]] <= '0;
            state <= FILL;
          end
        end
        FILL: begin
          if (in_valid) begin
            blk[wcnt[3:0]] <= in_data;
            wcnt           <= wcnt + 5'd1;
            if (wcnt == 5'd15 || in_last) begin
              last  <= in_last;
              state <= ISSUE;
            end
          end
        end
        ISSUE: begin
          if (core_ready) begin
            if (first) core_init <= 1'b1;
            else       core_next <= 1'b1;
            first <= 1'b0;
            state <= WAIT_BUSY;
          end
        end
        WAIT_BUSY: begin
          // core_valid may still be high from the previous block until ready drops.
          if (!core_ready) state <= WAIT_VALID;
        end
        WAIT_VALID: begin
          if (core_valid) begin
            for (int unsigned k = 0; k < 16; k++) begin
              obuf[k[3:0]] <= core_data_out[511-32*k -: 32];
            end
            blocks_done <= blocks_done + CTR_W'(1);
            rd          <= '0;
            state       <= DRAIN;
          end
        end
        DRAIN: begin
          if (out_ready) begin
            if (rd_final) begin
              rd <= '0;
              if (last) begin
                state <= FINISH;
              end else begin
                wcnt <= '0;
                for (int unsigned k = 0; k < 16; k++) blk[k[3:0]] <= '0;
                state <= FILL;
              end
            end else begin
              rd <= rd + 4'd1;
            end
          end
        end
        FINISH: begin
          if (core_ready) begin
            core_done <= 1'b1;
            busy      <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_chacha20_poly1305_stream.sv
// Randomized bench for chacha20_poly1305_stream with a behavioural AEAD core stand-in
// and a message-level reference model (blocks of 16 words, result = data ^ mask).
module tb_chacha20_poly1305_stream;

  localparam int CTR_W = 32;

  logic             clk = 1'b0;
  logic             reset_n;
  logic             start;
  logic             busy;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_data;
  logic             in_last;
  logic             out_valid;
  logic             out_ready;
  logic [31:0]      out_data;
  logic             out_last;
  logic             core_init;
  logic             core_next;
  logic             core_done;
  logic             core_ready;
  logic             core_valid;
  logic [511:0]     core_data_in;
  logic [511:0]     core_data_out;
  logic [CTR_W-1:0] blocks_done;

  chacha20_poly1305_stream #(.CTR_W(CTR_W)) dut (
    .clk(clk), .reset_n(reset_n), .start(start), .busy(busy),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data), .in_last(in_last),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .core_init(core_init), .core_next(core_next), .core_done(core_done),
    .core_ready(core_ready), .core_valid(core_valid),
    .core_data_in(core_data_in), .core_data_out(core_data_out),
    .blocks_done(blocks_done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core stand-in: accepts a command while idle, keeps the previous result valid
  // for a random while, then drops ready/valid and later returns data ^ mask.
  logic [31:0]  mask;
  logic [511:0] cap;
  logic [511:0] cap_q[$];
  int           ph, lat;
  int           n_init = 0, n_next = 0, n_done = 0, n_proto = 0;

  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      core_ready    <= 1'b1;
      core_valid    <= 1'b0;
      core_data_out <= '0;
      ph            <= 0;
      lat           <= 0;
    end else begin
      if (core_init) n_init <= n_init + 1;
      if (core_next) n_next <= n_next + 1;
      if (core_done) n_done <= n_done + 1;
      if ((int'(core_init) + int'(core_next) + int'(core_done)) > 1 ||
          ((core_init || core_next || core_done) && ph != 0))
        n_proto <= n_proto + 1;
      case (ph)
        0: if (core_init || core_next) begin
          cap_q.push_back(core_data_in);
          cap <= core_data_in;
          lat <= $urandom_range(0, 3);
          ph  <= 1;
        end
        1: if (lat == 0) begin
          core_ready <= 1'b0;
          core_valid <= 1'b0;
          lat        <= $urandom_range(0, 4);
          ph         <= 2;
        end else lat <= lat - 1;
        default: if (lat == 0) begin
          core_data_out <= cap ^ {16{mask}};
          core_valid    <= 1'b1;
          core_ready    <= 1'b1;
          ph            <= 0;
        end else lat <= lat - 1;
      endcase
    end
  end

  logic [31:0] msg[$];

  task automatic check_all_zero(input string pfx);
    chk({pfx, "_busy"},      busy, 0);
    chk({pfx, "_in_ready"},  in_ready, 0);
    chk({pfx, "_out_valid"}, out_valid, 0);
    chk({pfx, "_out_data"},  out_data, 0);
    chk({pfx, "_out_last"},  out_last, 0);
    chk({pfx, "_core_cmd"},  {core_init, core_next, core_done}, 0);
    chk({pfx, "_core_din"},  core_data_in, 0);
    chk({pfx, "_blocks"},    blocks_done, 0);
  endtask

  task automatic run_msg(input int abort_at);
    int n, nb, idx, oidx, cyc, b_init, b_next, b_done, b_cap, b_proto;
    bit done_seen, stalled, aborted;
    logic [31:0]  prev;
    logic [511:0] exp;
    n = msg.size();
    nb = (n + 15) / 16;
    b_init = n_init; b_next = n_next; b_done = n_done; b_cap = cap_q.size(); b_proto = n_proto;
    idx = 0; oidx = 0; cyc = 0; done_seen = 0; stalled = 0; aborted = 0; prev = '0;
    @(negedge clk); start = 1'b1;
    @(posedge clk); #1 start = 1'b0;
    chk("busy_after_start", busy, 1);
    @(negedge clk);
    while (!done_seen && !aborted && cyc < 3000) begin
      in_valid  = (idx < n) && ($urandom_range(0, 3) != 0);
      in_data   = in_valid ? msg[idx] : $urandom;
      in_last   = in_valid && (idx == n - 1);
      out_ready = ($urandom_range(0, 2) != 0);
      start     = busy && ($urandom_range(0, 9) == 0);
      if (in_valid && in_ready) idx++;
      if (out_valid) begin
        chk("in_ready_in_drain", in_ready, 0);
        if (stalled) chk("stall_hold", out_data, prev);
        if (out_ready) begin
          chk($sformatf("out_data[%0d]", oidx), out_data, (oidx < n) ? (msg[oidx] ^ mask) : 32'hx);
          chk($sformatf("out_last[%0d]", oidx), out_last, oidx == n - 1);
          oidx++;
          stalled = 0;
        end else begin
          stalled = 1;
          prev    = out_data;
        end
      end
      @(posedge clk); #1;
      start = 1'b0;
      if (core_done) done_seen = 1;
      if (abort_at != 0 && oidx >= abort_at && out_valid) begin
        #2 reset_n = 1'b0;
        #1 check_all_zero("abort");
        in_valid = 1'b0; out_ready = 1'b0;
        @(negedge clk); reset_n = 1'b1;
        aborted = 1;
      end
      if (!aborted) @(negedge clk);
      cyc++;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b0; start = 1'b0;
    if (abort_at != 0) begin
      chk("abort_reached", aborted, 1);
      return;
    end
    chk("done_seen", done_seen, 1);
    chk("busy_cleared", busy, 0);
    chk("out_count", oidx, n);
    chk("blocks_done", blocks_done, nb);
    @(posedge clk); #1;
    chk("init_count", n_init - b_init, 1);
    chk("next_count", n_next - b_next, nb - 1);
    chk("done_count", n_done - b_done, 1);
    chk("protocol", n_proto - b_proto, 0);
    chk("block_count", cap_q.size() - b_cap, nb);
    for (int b = 0; b < nb && b_cap + b < cap_q.size(); b++) begin
      exp = '0;
      for (int j = 0; j < 16 && 16 * b + j < n; j++) exp[511-32*j -: 32] = msg[16*b+j];
      chk($sformatf("core_din_blk%0d", b), cap_q[b_cap+b], exp);
    end
  endtask

  initial begin
    reset_n = 1'b0; start = 1'b0; in_valid = 1'b0; in_data = '0; in_last = 1'b0;
    out_ready = 1'b0; mask = '0;
    #12 check_all_zero("reset");
    @(negedge clk) reset_n = 1'b1;

    // 16-word echo message
    msg.delete();
    for (int i = 1; i <= 16; i++) msg.push_back(32'(i));
    run_msg(0);

    // 17 random words, nonzero mask
    mask = $urandom;
    msg.delete();
    for (int i = 0; i < 17; i++) msg.push_back($urandom);
    run_msg(0);

    // 3-word partial block
    mask = 32'h0;
    msg.delete();
    msg.push_back(32'hA); msg.push_back(32'hB); msg.push_back(32'hC);
    run_msg(0);

    // random lengths including 1, 15, 32, 33
    for (int t = 0; t < 6; t++) begin
      int len;
      case (t)
        0: len = 1;
        1: len = 15;
        2: len = 32;
        3: len = 33;
        default: len = $urandom_range(2, 40);
      endcase
      mask = $urandom;
      msg.delete();
      for (int i = 0; i < len; i++) msg.push_back($urandom);
      run_msg(0);
    end

    // asynchronous reset mid-drain, then a 1-word message
    mask = $urandom;
    msg.delete();
    for (int i = 0; i < 20; i++) msg.push_back($urandom);
    run_msg(5);
    msg.delete();
    msg.push_back($urandom);
    run_msg(0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/chacha20_poly1305_stream.md
Name: chacha20_poly1305_stream

Overview:
Host-side sequencer that drives the ChaCha20-Poly1305 AEAD core from a 32-bit word stream. It packs incoming words into 512-bit blocks and issues init for the first block and next for each later block. It captures each 512-bit result and unpacks it to an outgoing 32-bit word stream, then pulses done after the final block. It sits between the bus/DMA interface and the AEAD core; key, iv, ctr and encdec are wired to the core elsewhere.

Parameters:
CTR_W, 32, width of the processed-block counter.

Ports:
clk  in  1  system clock
reset_n  in  1  asynchronous active-low reset
start  in  1  single-cycle pulse: begin a new message
busy  out  1  high from accepted start until done pulse issued
in_valid  in  1  input word valid
in_ready  out  1  input word accepted when in_valid&&in_ready
in_data  in  32  input word
in_last  in  1  marks final word of message
out_valid  out  1  output word valid
out_ready  in  1  output word consumed when out_valid&&out_ready
out_data  out  32  output word
out_last  out  1  marks final output word of message
core_init  out  1  init pulse to AEAD core (first block)
core_next  out  1  next pulse to AEAD core (later blocks)
core_done  out  1  done pulse to AEAD core (end of message)
core_ready  in  1  core idle / able to accept init, next or done
core_valid  in  1  core result valid (level)
core_data_in  out  512  packed block to core
core_data_out  in  512  result block from core
blocks_done  out  CTR_W  blocks completed in current message

Behaviour:
- Reset (async, reset_n=0): all registers cleared. State IDLE. All outputs 0, including core_data_in and blocks_done.
- Packing: word k of a block (k=0..15) occupies core_data_in[511-32k -: 32]. Unfilled words of a partial block are 0. Word count wcnt (1..16) is kept per block.
- States and transitions:
  - IDLE: busy=0. On start: clear blocks_done, set first flag, go FILL. start is ignored in every other state.
  - FILL: in_ready=1. Each accepted word is stored at index wcnt. On the 16th word or a word with in_last: latch last flag, go ISSUE. in_last on the 16th word gives a full final block.
  - ISSUE: wait core_ready=1. Then register exactly one cycle of core_init (first=1) or core_next (first=0), clear first, go WAIT_BUSY.
  - WAIT_BUSY: wait core_ready=0, then go WAIT_VALID. This ignores a stale core_valid from the previous block.
  - WAIT_VALID: wait core_valid=1. Capture core_data_out into the output buffer, increment blocks_done (wraps mod 2^CTR_W), go DRAIN.
  - DRAIN: out_valid=1. Emits buffer words 0..wcnt-1 in packing order; out_data is stable while out_valid&&!out_ready. out_last=1 only on word wcnt-1 of a block with last set. After the final word is accepted: go FINISH if last, else clear wcnt and the block buffer and go FILL.
  - FINISH: wait core_ready=1. Register exactly one cycle of core_done, clear busy, go IDLE.
- Output signals by state:
  - in_ready is 0 outside FILL; in_valid is ignored there.
  - out_valid is 0 outside DRAIN.
  - core_init, core_next and core_done are never asserted together.
- Latency: the first core pulse occurs no earlier than 1 cycle after the block-closing word is accepted. The first out_valid occurs 1 cycle after core_valid is sampled high in WAIT_VALID.
- Throughput: one word per cycle in FILL and DRAIN; there is no overlap between FILL and DRAIN.
- Minimum message is one word (in_last accompanies a word). There is no timeout; a core that never raises core_valid stalls the block.
- Reset mid-message aborts all state immediately; no done pulse is issued.

Test Plan:
- 16 words 0x00000001..0x00000010, last on word 16, core model echoes data: core_data_in[511:480]=0x1 and [31:0]=0x10; one core_init, no core_next; out yields 0x1..0x10 with out_last on the 16th; one core_done; blocks_done=1.
- 17-word message: one init then one next; second core_data_in = word17 in [511:480], rest 0; 17 output words, out_last on the 17th only; blocks_done=2.
- 3-word message 0xA,0xB,0xC: core_data_in = {0xA,0xB,0xC,13×0}; exactly 3 output words; out_last on 0xC.
- out_ready toggled 1-0-1 pseudo-randomly during DRAIN: out_data stable while stalled; no word lost or duplicated; in_ready stays 0 throughout.
- start pulsed in FILL and in WAIT_VALID: ignored, blocks_done not cleared; core_valid held high from prior block: no capture until core_ready has fallen.
- reset_n=0 asserted asynchronously mid-DRAIN: all outputs 0 immediately without a clock edge; after release, a new 1-word message completes normally with blocks_done=1.
